// File: rtl/nonoverlap_clkgen_pkg.sv
// Shared types for the multiphase non-overlapping clock generator.
// Latency: n/a (types and a combinational config check). Backpressure: n/a.
// cfg_t is sized from the *_DEF widths; the top parameters default to them and must move together.
package nonoverlap_clkgen_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 8;
    localparam int DEAD_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    typedef struct packed {
        logic [NUM_CH_DEF*CNT_W_DEF-1:0] phase;
        logic [CNT_W_DEF-1:0]            period;
        logic [CNT_W_DEF-1:0]            high;
        logic [DEAD_W_DEF-1:0]           dead;
    } cfg_t;

    // A word is usable only if both phases keep at least one tick of CLKN high
    // and every channel offset lies inside one period.
    function automatic logic cfg_ok(input cfg_t c);
        int   low_ticks;
        logic ok;
        low_ticks = int'(c.period) + 1 - int'(c.high) - 2 * int'(c.dead);
        ok = (c.high != '0) && (low_ticks >= 1);
        for (int i = 0; i < NUM_CH_DEF; i++) begin
            if (c.phase[i*CNT_W_DEF +: CNT_W_DEF] > c.period) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/nonoverlap_phase_chan.sv
// One CLK/CLKN pair: phase-shifted position in the period compared against high/dead windows.
// Latency: 1 cycle from cnt to registered outputs. Backpressure: none, free-running.
module nonoverlap_phase_chan #(
    parameter int CNT_W  = 8,
    parameter int DEAD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [CNT_W-1:0]  ph,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  high,
    input  logic [DEAD_W-1:0] dead,
    output logic              ph_clk,
    output logic              ph_clkn
);

    // Two guard bits so high+dead and period+1 never wrap.
    localparam int LW = CNT_W + 2;

    logic [LW-1:0] p_ticks;
    logic [LW-1:0] lag;
    logic [LW-1:0] hi_end;
    logic [LW-1:0] lo_end;
    logic          clk_lvl;
    logic          clkn_lvl;

    always_comb begin
        p_ticks  = LW'(period) + LW'(1);
        lag      = (cnt >= ph) ? (LW'(cnt) - LW'(ph)) : (LW'(cnt) + p_ticks - LW'(ph));
        hi_end   = LW'(high) + LW'(dead);
        lo_end   = p_ticks - LW'(dead);
        clk_lvl  = lag < LW'(high);
        clkn_lvl = (lag >= hi_end) && (lag < lo_end);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_clk  <= 1'b0;
            ph_clkn <= 1'b0;
        end else begin
            ph_clk  <= run & clk_lvl;
            ph_clkn <= run & clkn_lvl;
        end
    end

endmodule

// File: rtl/multiphase_nonoverlap_clkgen.sv
// NUM_CH non-overlapping CLK/CLKN pairs with runtime period/high/dead/phase and graceful stop.
// Latency: outputs lag the period counter by 1 cycle. Backpressure: CFG_READY low while a word is pending.
module multiphase_nonoverlap_clkgen
    import nonoverlap_clkgen_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEAD_W = DEAD_W_DEF
) (
    input  logic                    USER_CLOCK,
    input  logic                    RESET_N,
    input  logic                    ENABLE,
    input  logic                    CFG_VALID,
    output logic                    CFG_READY,
    input  logic [CNT_W-1:0]        CFG_PERIOD,
    input  logic [CNT_W-1:0]        CFG_HIGH,
    input  logic [DEAD_W-1:0]       CFG_DEAD,
    input  logic [NUM_CH*CNT_W-1:0] CFG_PHASE,
    output logic [NUM_CH-1:0]       CLK_OUT,
    output logic [NUM_CH-1:0]       CLKN_OUT,
    output logic                    PERIOD_SYNC,
    output logic                    RUNNING,
    output logic                    CFG_ERR
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    cfg_t             cfg_in;
    cfg_t             act;
    cfg_t             pend;
    logic             act_vld;
    logic             pend_vld;
    logic             xfer;
    logic             cfg_good;
    logic             wrap;
    logic             apply;
    logic             running_q;
    logic             sync_q;
    logic             err_q;

    assign cfg_in    = '{phase: CFG_PHASE, period: CFG_PERIOD, high: CFG_HIGH, dead: CFG_DEAD};
    assign CFG_READY = ~pend_vld;
    assign xfer      = CFG_VALID & ~pend_vld;
    assign cfg_good  = cfg_ok(cfg_in);
    assign wrap      = (state != ST_IDLE) && (cnt == act.period);
    // Pending and free slot are mutually exclusive, so apply and a new accept never collide.
    assign apply     = pend_vld && ((state == ST_IDLE) || wrap);
    assign cnt_nxt   = wrap ? '0 : cnt + 1'b1;

    always_ff @(posedge USER_CLOCK) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            act       <= '0;
            act_vld   <= 1'b0;
            pend      <= '0;
            pend_vld  <= 1'b0;
            running_q <= 1'b0;
            sync_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q  <= xfer & ~cfg_good;
            sync_q <= (state != ST_IDLE) && (cnt == '0);
            if (apply) begin
                act      <= pend;
                act_vld  <= 1'b1;
                pend_vld <= 1'b0;
            end else if (xfer && cfg_good) begin
                pend     <= cfg_in;
                pend_vld <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (ENABLE && act_vld) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt_nxt;
                    if (!ENABLE) state <= ST_STOPPING;
                end
                ST_STOPPING: begin
                    cnt <= cnt_nxt;
                    if (ENABLE) begin
                        state <= ST_RUN;
                    end else if (wrap) begin
                        state     <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nonoverlap_phase_chan #(
            .CNT_W  (CNT_W),
            .DEAD_W (DEAD_W)
        ) u_chan (
            .clk     (USER_CLOCK),
            .rst_n   (RESET_N),
            .run     (state != ST_IDLE),
            .cnt     (cnt),
            .ph      (act.phase[i*CNT_W +: CNT_W]),
            .period  (act.period),
            .high    (act.high),
            .dead    (act.dead),
            .ph_clk  (CLK_OUT[i]),
            .ph_clkn (CLKN_OUT[i])
        );
    end

    assign PERIOD_SYNC = sync_q;
    assign RUNNING     = running_q;
    assign CFG_ERR     = err_q;

endmodule

// File: tb/tb_multiphase_nonoverlap_clkgen.sv
// Bench for multiphase_nonoverlap_clkgen: config table, directed waveform sequences, random run vs reference model.
module tb_multiphase_nonoverlap_clkgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cv;
    logic        rdy;
    logic [7:0]  cfg_per;
    logic [7:0]  cfg_high;
    logic [3:0]  cfg_dead;
    logic [31:0] cfg_ph;
    logic [3:0]  co;
    logic [3:0]  cno;
    logic        psync;
    logic        running;
    logic        err;

    always #5 clk = ~clk;

    multiphase_nonoverlap_clkgen dut (
        .USER_CLOCK  (clk),
        .RESET_N     (rst_n),
        .ENABLE      (en),
        .CFG_VALID   (cv),
        .CFG_READY   (rdy),
        .CFG_PERIOD  (cfg_per),
        .CFG_HIGH    (cfg_high),
        .CFG_DEAD    (cfg_dead),
        .CFG_PHASE   (cfg_ph),
        .CLK_OUT     (co),
        .CLKN_OUT    (cno),
        .PERIOD_SYNC (psync),
        .RUNNING     (running),
        .CFG_ERR     (err)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        else passes++;
    endtask

    // Reference model: run mode (0 idle, 1 run, 2 stopping), tick position, active and queued words.
    int   m_mode = 0, m_cnt = 0;
    int   a_per = 0, a_high = 0, a_dead = 0;
    int   a_ph[4] = '{0, 0, 0, 0};
    bit   a_vld = 0;
    int   q_per = 0, q_high = 0, q_dead = 0;
    int   q_ph[4] = '{0, 0, 0, 0};
    bit   q_vld = 0;
    logic [3:0] e_co = '0, e_cno = '0;
    logic e_sync = 0, e_run = 0, e_err = 0;

    function automatic bit ref_ok(int per, int high, int dead, logic [31:0] ph);
        if (high == 0) return 0;
        if (per + 1 - high - 2 * dead < 1) return 0;
        for (int i = 0; i < 4; i++) if (int'(ph[i*8 +: 8]) > per) return 0;
        return 1;
    endfunction

    task automatic model_step();
        int  p, l, nmode, ncnt;
        bit  wrap, apply, xfer, okv;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; a_vld = 0; q_vld = 0;
            e_co = '0; e_cno = '0; e_sync = 0; e_run = 0; e_err = 0;
            return;
        end
        p = a_per + 1;
        for (int i = 0; i < 4; i++) begin
            l = (m_cnt - a_ph[i] + p) % p;
            e_co[i]  = (m_mode != 0) && (l < a_high);
            e_cno[i] = (m_mode != 0) && (l >= a_high + a_dead) && (l < p - a_dead);
        end
        e_sync = (m_mode != 0) && (m_cnt == 0);
        xfer   = cv && !q_vld;
        okv    = ref_ok(int'(cfg_per), int'(cfg_high), int'(cfg_dead), cfg_ph);
        e_err  = xfer && !okv;
        wrap   = (m_mode != 0) && (m_cnt == a_per);
        apply  = q_vld && (m_mode == 0 || wrap);
        if (m_mode == 0) begin
            ncnt  = 0;
            nmode = (en && a_vld) ? 1 : 0;
        end else begin
            ncnt = wrap ? 0 : m_cnt + 1;
            if (en) nmode = 1;
            else if (m_mode == 2 && wrap) nmode = 0;
            else nmode = 2;
        end
        m_mode = nmode;
        m_cnt  = ncnt;
        if (apply) begin
            a_per = q_per; a_high = q_high; a_dead = q_dead; a_ph = q_ph;
            a_vld = 1; q_vld = 0;
        end else if (xfer && okv) begin
            q_per = int'(cfg_per); q_high = int'(cfg_high); q_dead = int'(cfg_dead);
            for (int i = 0; i < 4; i++) q_ph[i] = int'(cfg_ph[i*8 +: 8]);
            q_vld = 1;
        end
        e_run = (nmode != 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model", {20'd0, rdy, co, cno, psync, running, err},
                     {20'd0, ~q_vld, e_co, e_cno, e_sync, e_run, e_err});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [7:0] per, input logic [7:0] high, input logic [3:0] dead,
                        input logic [31:0] ph);
        cfg_per = per; cfg_high = high; cfg_dead = dead; cfg_ph = ph;
        cv = 1'b1;
        tick();
        cv = 1'b0;
    endtask

    task automatic wait_sync(input string tag);
        int n = 0;
        while (!psync && n < 40) begin
            tick();
            n++;
        end
        chk(tag, psync, 1'b1);
    endtask

    // Current sample must be the PERIOD_SYNC one: samples j=0..9 then show counter positions 0..9.
    task automatic collect(output logic [9:0] c0, output logic [9:0] n0,
                           output logic [9:0] c1, output logic [9:0] n1, output bit overlap);
        overlap = 0;
        for (int j = 0; j < 10; j++) begin
            c0[j] = co[0]; n0[j] = cno[0]; c1[j] = co[1]; n1[j] = cno[1];
            if ((co & cno) != '0) overlap = 1;
            tick();
        end
    endtask

    // Sync sample means the counter already sits at 1; two more edges land on 3.
    task automatic goto_cnt3(input string tag);
        wait_sync(tag);
        tick();
        tick();
    endtask

    typedef struct {
        logic [7:0]  per;
        logic [7:0]  high;
        logic [3:0]  dead;
        logic [31:0] ph;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [9:0] c0, n0, c1, n1;
        bit         ovl;
        int         n;
        bit         bad;

        vecs[0] = '{8'd9,   8'd4,   4'd1,  32'h0000_0000, 1'b0};
        vecs[1] = '{8'd9,   8'd6,   4'd2,  32'h0000_0000, 1'b1};
        vecs[2] = '{8'd9,   8'd0,   4'd0,  32'h0000_0000, 1'b1};
        vecs[3] = '{8'd9,   8'd7,   4'd1,  32'h0000_0000, 1'b0};
        vecs[4] = '{8'd9,   8'd8,   4'd1,  32'h0000_0000, 1'b1};
        vecs[5] = '{8'd9,   8'd3,   4'd0,  32'h000A_0000, 1'b1};
        vecs[6] = '{8'd9,   8'd3,   4'd0,  32'h0900_0000, 1'b0};
        vecs[7] = '{8'd255, 8'd200, 4'd15, 32'hFF10_2030, 1'b0};
        vecs[8] = '{8'd0,   8'd1,   4'd0,  32'h0000_0000, 1'b1};
        vecs[9] = '{8'd1,   8'd1,   4'd0,  32'h0001_0001, 1'b0};

        rst_n = 1'b0; en = 1'b0; cv = 1'b0;
        cfg_per = '0; cfg_high = '0; cfg_dead = '0; cfg_ph = '0;
        tick();
        tick();
        chk("reset_ready", rdy, 1'b1);
        chk("reset_outs", {co, cno, psync, running, err}, 11'd0);
        rst_n = 1'b1;

        // Config acceptance table; rejected words must leave ENABLE without effect.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            load(vecs[v].per, vecs[v].high, vecs[v].dead, vecs[v].ph);
            chk($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
            chk($sformatf("vec%0d_ready", v), rdy, vecs[v].exp_err);
            tick();
            chk($sformatf("vec%0d_err_pulse", v), err, 1'b0);
            if (vecs[v].exp_err) begin
                en = 1'b1;
                bad = 0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    if (running) bad = 1;
                end
                chk($sformatf("vec%0d_enable_ignored", v), bad, 1'b0);
                en = 1'b0;
            end
        end

        // Basic four-phase waveform.
        do_reset();
        load(8'd9, 8'd4, 4'd1, 32'h0902_0500);
        tick();
        en = 1'b1;
        wait_sync("s1_sync");
        collect(c0, n0, c1, n1, ovl);
        chk("s1_clk0", c0, 10'b0000001111);
        chk("s1_clkn0", n0, 10'b0111100000);
        chk("s1_clk1", c1, 10'b0111100000);
        chk("s1_clkn1", n1, 10'b0000001111);
        chk("s1_overlap", ovl, 1'b0);

        // Reconfigure mid-period: held until the wrap.
        goto_cnt3("s3_sync");
        load(8'd9, 8'd2, 4'd1, 32'h0902_0500);
        chk("s3_ready_low", rdy, 1'b0);
        n = 0;
        while (!rdy && n < 50) begin
            tick();
            n++;
        end
        chk("s3_ready_wait", n, 6);
        wait_sync("s3_sync2");
        collect(c0, n0, c1, n1, ovl);
        chk("s3_clk0", c0, 10'b0000000011);
        chk("s3_clkn0", n0, 10'b0111111000);

        // Graceful stop finishes the period.
        goto_cnt3("s4_sync");
        en = 1'b0;
        n = 0;
        while (running && n < 50) begin
            tick();
            n++;
        end
        chk("s4_stop_ticks", n, 7);
        tick();
        chk("s4_idle_outs", {co, cno, psync}, 9'd0);
        en = 1'b1;
        goto_cnt3("s4_sync2");
        en = 1'b0;
        tick(); tick(); tick();
        en = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!running) bad = 1;
        end
        chk("s4_no_gap", bad, 1'b0);

        // Phase equal to the period wraps around.
        do_reset();
        en = 1'b0;
        load(8'd9, 8'd3, 4'd1, 32'h0000_0009);
        tick();
        en = 1'b1;
        wait_sync("s5_sync");
        collect(c0, n0, c1, n1, ovl);
        chk("s5_clk0", c0, 10'b1000000011);
        chk("s5_clkn0", n0, 10'b0011111000);

        // Reset mid-run drops everything including the active config.
        goto_cnt3("s6_sync");
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("s6_outs", {co, cno, psync, running, err}, 11'd0);
        chk("s6_ready", rdy, 1'b1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (running) bad = 1;
        end
        chk("s6_enable_ignored", bad, 1'b0);

        // Random traffic against the reference model.
        en = 1'b0;
        for (int it = 0; it < 4000; it++) begin
            int per;
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 24) == 0) en = ~en;
            cv      = ($urandom_range(0, 5) == 0);
            per     = $urandom_range(1, 20);
            cfg_per  = 8'(per);
            cfg_high = 8'($urandom_range(0, per + 1));
            cfg_dead = 4'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                cfg_ph[i*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'(per + 1)
                                                                : 8'($urandom_range(0, per));
            end
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
